// File: rtl/regfile_arb_pkg.sv
// Shared widths and FSM state type for the register-file write-port arbiter.
// Pure definitions; nothing here creates logic of its own.
package regfile_arb_pkg;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  typedef enum logic {ARB, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker, purely combinational: the first set request after last wins.
// No backpressure of its own; the caller decides whether the pick becomes a grant.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  logic [IW:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    // Walk offsets 1..N so the previous winner is checked last.
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, last} + (IW+1)'(off);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!gnt_vld && req[cand[IW-1:0]]) begin
        gnt_vld               = 1'b1;
        gnt_idx               = cand[IW-1:0];
        gnt[cand[IW-1:0]]     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter with bounded lock bursts; winning write appears 1 cycle after handshake.
// wr_stall or reset drop every req_ready; the registered output stage still drains.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_LOCK = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic                       wr_stall,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          WriteReg,
  output logic [DATA_W-1:0]          WriteData,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;
  logic                hs;
  logic [IDX_W-1:0]    hs_idx;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_lock;

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req     (req_valid),
    .last    (last_grant_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  always_comb begin
    req_ready = '0;
    hs        = 1'b0;
    hs_idx    = pick_idx;
    if (reset && !wr_stall) begin
      // A lock owner keeps the port even while idle; nobody else may slip in.
      if (state_q == LOCKED) begin
        if (req_valid[lock_owner_q]) begin
          req_ready[lock_owner_q] = 1'b1;
          hs                      = 1'b1;
          hs_idx                  = lock_owner_q;
        end
      end else begin
        req_ready = pick_gnt;
        hs        = pick_vld;
      end
    end
  end

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_idx == IDX_W'(i)) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_lock = req_lock[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;
    reg_write_d  = hs;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    if (hs) begin
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      grant_id_d   = hs_idx;
      last_grant_d = hs_idx;
      if (state_q == ARB) begin
        if (sel_lock && (MAX_LOCK > 1)) begin
          state_d      = LOCKED;
          lock_owner_d = hs_idx;
          lock_cnt_d   = CNT_W'(1);
        end
      end else if (sel_lock && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else begin
        // Voluntary or forced release; last_grant = owner so rotation resumes past it.
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ARB;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign grant_id  = grant_id_q;
  assign locked    = (state_q == LOCKED);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: per-cycle vectors with expected ready/locked,
// expected write-port contents queued at the handshake and checked one cycle later.
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [5:0]  req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_lock;
  logic        wr_stall;
  logic        RegWrite;
  logic [1:0]  WriteReg;
  logic [31:0] WriteData;
  logic [1:0]  grant_id;
  logic        locked;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .wr_stall  (wr_stall),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] vld;
    logic [2:0] lck;
    logic       stall;
    logic       rst_n;
    logic [2:0] exp_rdy;
    logic       exp_lk;
  } vec_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rg;
    logic [31:0] d;
    logic [1:0]  id;
  } out_t;

  vec_t        tbl[$];
  out_t        sb[$];
  out_t        m;
  logic [1:0]  r_arr[3];
  logic [31:0] d_arr[3];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  function automatic vec_t mk(input logic [2:0] vld, input logic [2:0] lck, input logic stall,
                              input logic rst_n, input logic [2:0] rdy, input logic lk);
    vec_t v;
    v.vld = vld; v.lck = lck; v.stall = stall; v.rst_n = rst_n; v.exp_rdy = rdy; v.exp_lk = lk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic fill_default();
    for (int i = 0; i < 3; i++) begin
      d_arr[i] = {4'(i), 28'(cyc)};
      r_arr[i] = 2'(cyc + i);
    end
  endtask

  task automatic step(input vec_t v);
    out_t e;
    int   id;
    @(negedge clk);
    reset    = v.rst_n;
    wr_stall = v.stall;
    req_valid = v.vld;
    req_lock = v.lck;
    for (int i = 0; i < 3; i++) begin
      req_reg[i*2 +: 2]   = r_arr[i];
      req_data[i*32 +: 32] = d_arr[i];
    end
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.exp_rdy));
    chk("locked", 32'(locked), 32'(v.exp_lk));
    id = -1;
    for (int i = 0; i < 3; i++) if (v.exp_rdy[i]) id = i;
    if (!v.rst_n) m = '{rw: 1'b0, rg: 2'd0, d: 32'd0, id: 2'd0};
    else if (id >= 0) m = '{rw: 1'b1, rg: r_arr[id], d: d_arr[id], id: 2'(id)};
    else m.rw = 1'b0;
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("RegWrite", 32'(RegWrite), 32'(e.rw));
    chk("WriteReg", 32'(WriteReg), 32'(e.rg));
    chk("WriteData", WriteData, e.d);
    chk("grant_id", 32'(grant_id), 32'(e.id));
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; wr_stall = 1'b0; req_valid = '0; req_lock = '0; req_reg = '0; req_data = '0;
    m = '0;
    fill_default();
    repeat (2) @(posedge clk);

    // Reset state, then a single requester 1 write of 0xDEADBEEF to register 2.
    step(mk(3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0));
    d_arr[1] = 32'hDEADBEEF;
    r_arr[1] = 2'd2;
    step(mk(3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0));
    chk("t1_regwrite", 32'(RegWrite), 32'd1);
    chk("t1_reg", 32'(WriteReg), 32'd2);
    chk("t1_data", WriteData, 32'hDEADBEEF);
    chk("t1_id", 32'(grant_id), 32'd1);
    fill_default();
    step(mk(3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0));

    // Round robin from reset
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b001, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b001, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0));
    tbl.push_back(mk(3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0));
    // Requester 2 locks for the full MAX_LOCK burst, then 0 wins
    tbl.push_back(mk(3'b111, 3'b100, 1'b0, 1'b1, 3'b100, 1'b0));
    tbl.push_back(mk(3'b111, 3'b100, 1'b0, 1'b1, 3'b100, 1'b1));
    tbl.push_back(mk(3'b111, 3'b100, 1'b0, 1'b1, 3'b100, 1'b1));
    tbl.push_back(mk(3'b111, 3'b100, 1'b0, 1'b1, 3'b100, 1'b1));
    tbl.push_back(mk(3'b111, 3'b100, 1'b0, 1'b1, 3'b001, 1'b0));
    // Owner 1 goes idle for two cycles while 0 waits, then resumes and releases
    tbl.push_back(mk(3'b011, 3'b010, 1'b0, 1'b1, 3'b010, 1'b0));
    tbl.push_back(mk(3'b001, 3'b010, 1'b0, 1'b1, 3'b000, 1'b1));
    tbl.push_back(mk(3'b001, 3'b010, 1'b0, 1'b1, 3'b000, 1'b1));
    tbl.push_back(mk(3'b011, 3'b010, 1'b0, 1'b1, 3'b010, 1'b1));
    tbl.push_back(mk(3'b011, 3'b000, 1'b0, 1'b1, 3'b010, 1'b1));
    tbl.push_back(mk(3'b011, 3'b000, 1'b0, 1'b1, 3'b001, 1'b0));
    // Three stall cycles; rotation resumes from last grant 0
    tbl.push_back(mk(3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0));
    // Reset in the middle of a lock burst by requester 0
    tbl.push_back(mk(3'b111, 3'b001, 1'b0, 1'b1, 3'b001, 1'b0));
    tbl.push_back(mk(3'b111, 3'b001, 1'b0, 1'b1, 3'b001, 1'b1));
    tbl.push_back(mk(3'b111, 3'b001, 1'b0, 1'b0, 3'b000, 1'b1));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b001, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 1'b0, 1'b1, 3'b100, 1'b0));

    for (int k = 0; k < tbl.size(); k++) begin
      fill_default();
      step(tbl[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
